// File: rtl/vector_mac.sv
// vector_mac: multi-lane signed multiply-accumulator with grouped results.
//
// Each accepted beat multiplies LANES signed operand pairs, sums the products
// and adds that sum into a wide accumulator. A beat flagged iLast closes the
// group; the converted result (saturating or wrapping, chosen per group) is
// held on oRes with a valid/acknowledge handshake.
//
// Ports:
//   iClk      clock, rising edge
//   iRst      synchronous active-high reset
//   iValid    beat present on iA/iB
//   iA, iB    packed signed operands, lane k at [k*INPUT_LENGTH +: INPUT_LENGTH]
//   iLast     beat closes the current group (qualified by iValid)
//   iSat      conversion mode for the group, sampled with the last beat
//   iAck      consumer takes oRes this cycle
//   oReady    beat accepted when iValid && oReady
//   oRes      converted group result
//   oValid    oRes holds an unacknowledged result
//   oOverflow group sum was outside the signed OUTPUT_LENGTH range
module vector_mac #(
  parameter int INPUT_LENGTH  = 16,
  parameter int LANES         = 4,
  parameter int ACC_LENGTH    = 40,
  parameter int OUTPUT_LENGTH = 32
) (
  input  logic                            iClk,
  input  logic                            iRst,
  input  logic                            iValid,
  input  logic [LANES*INPUT_LENGTH-1:0]   iA,
  input  logic [LANES*INPUT_LENGTH-1:0]   iB,
  input  logic                            iLast,
  input  logic                            iSat,
  input  logic                            iAck,
  output logic                            oReady,
  output logic [OUTPUT_LENGTH-1:0]        oRes,
  output logic                            oValid,
  output logic                            oOverflow
);

  localparam int PW = 2 * INPUT_LENGTH;

  localparam logic [OUTPUT_LENGTH-1:0] RES_MAX = {1'b0, {(OUTPUT_LENGTH-1){1'b1}}};
  localparam logic [OUTPUT_LENGTH-1:0] RES_MIN = {1'b1, {(OUTPUT_LENGTH-1){1'b0}}};

  // Stage 1: full-precision lane products
  logic signed [PW-1:0]         prod_d [LANES];
  logic signed [PW-1:0]         prod_q [LANES];
  logic                         v1_q, last1_q, sat1_q;

  // Stage 2: lane sum at accumulator width
  logic [ACC_LENGTH-1:0]        sum2_d, sum2_q;
  logic                         v2_q, last2_q, sat2_q;

  // Stage 3: accumulator and held result
  logic [ACC_LENGTH-1:0]        acc_q;
  logic [ACC_LENGTH-1:0]        t_d;
  logic                         in_range_d;
  logic [OUTPUT_LENGTH-1:0]     conv_d;
  logic [OUTPUT_LENGTH-1:0]     res_q;
  logic                         valid_q, ovf_q;

  logic                         en;

  // The whole pipeline freezes while a result waits unacknowledged.
  assign en     = !(valid_q && !iAck);
  assign oReady = en;

  assign oRes      = res_q;
  assign oValid    = valid_q;
  assign oOverflow = ovf_q;

  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      // Sign-extend both operands to PW first so the product keeps full precision.
      prod_d[k] = PW'($signed(iA[k*INPUT_LENGTH +: INPUT_LENGTH]))
                * PW'($signed(iB[k*INPUT_LENGTH +: INPUT_LENGTH]));
    end
  end

  always_comb begin
    sum2_d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      sum2_d = sum2_d + ACC_LENGTH'(prod_q[k]);
    end
  end

  always_comb begin
    t_d = acc_q + sum2_q;
    // t fits the signed output range iff all bits from the output sign bit upward agree.
    in_range_d = (t_d[ACC_LENGTH-1:OUTPUT_LENGTH-1] == '0)
              || (t_d[ACC_LENGTH-1:OUTPUT_LENGTH-1] == '1);
    conv_d = t_d[OUTPUT_LENGTH-1:0];
    if (!in_range_d && sat2_q) begin
      conv_d = t_d[ACC_LENGTH-1] ? RES_MIN : RES_MAX;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        prod_q[k] <= '0;
      end
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      sat1_q  <= 1'b0;
      sum2_q  <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      sat2_q  <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (en) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          prod_q[k] <= prod_d[k];
        end
        v1_q    <= iValid;
        last1_q <= iLast;
        sat1_q  <= iSat;

        sum2_q  <= sum2_d;
        v2_q    <= v1_q;
        last2_q <= last1_q;
        sat2_q  <= sat1_q;

        if (v2_q) begin
          if (last2_q) begin
            acc_q <= '0;
            res_q <= conv_d;
            ovf_q <= !in_range_d;
          end else begin
            acc_q <= t_d;
          end
        end
      end

      // A new result landing wins over an acknowledge on the same edge.
      if (en && v2_q && last2_q) begin
        valid_q <= 1'b1;
      end else if (iAck) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vector_mac.sv
module tb_vector_mac;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, v, last, sat, ack;
  logic [63:0] a, b;

  logic        rdy4, val4, ovf4;
  logic [31:0] res4;
  logic        rdy1, val1, ovf1;
  logic [31:0] res1;

  int checks = 0;
  int errors = 0;

  vector_mac #(.INPUT_LENGTH(16), .LANES(4), .ACC_LENGTH(40), .OUTPUT_LENGTH(32)) dut4 (
    .iClk(clk), .iRst(rst), .iValid(v), .iA(a), .iB(b), .iLast(last), .iSat(sat),
    .iAck(ack), .oReady(rdy4), .oRes(res4), .oValid(val4), .oOverflow(ovf4)
  );

  vector_mac #(.INPUT_LENGTH(16), .LANES(1), .ACC_LENGTH(40), .OUTPUT_LENGTH(32)) dut1 (
    .iClk(clk), .iRst(rst), .iValid(v), .iA(a[15:0]), .iB(b[15:0]), .iLast(last), .iSat(sat),
    .iAck(ack), .oReady(rdy1), .oRes(res1), .oValid(val1), .oOverflow(ovf1)
  );

  typedef struct {
    logic        v;
    logic [63:0] a;
    logic [63:0] b;
    logic        last;
    logic        sat;
    logic        ev;
    logic [31:0] eres;
    logic        eovf;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] pk(input int x0, input int x1, input int x2, input int x3);
    return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
  endfunction

  function automatic vec_t mk(input logic vi, input logic [63:0] ai, input logic [63:0] bi,
                              input logic li, input logic si, input logic ev,
                              input logic [31:0] er, input logic eo);
    vec_t r;
    r.v = vi; r.a = ai; r.b = bi; r.last = li; r.sat = si;
    r.ev = ev; r.eres = er; r.eovf = eo;
    return r;
  endfunction

  task automatic chk(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, what, got, exp);
    end
  endtask

  // Apply inputs for one cycle (after the falling edge); outputs are then sampled
  // mid-cycle, before the rising edge that consumes these inputs.
  task automatic drive(input logic r, input logic vi, input logic [63:0] ai, input logic [63:0] bi,
                       input logic li, input logic si, input logic ki);
    @(negedge clk);
    rst = r; v = vi; a = ai; b = bi; last = li; sat = si; ack = ki;
    #1;
  endtask

  task automatic idle(input logic ki);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, ki);
  endtask

  task automatic exp4(input string tag, input logic ev, input logic [31:0] er, input logic eo, input logic erdy);
    chk(tag, "valid", 32'(val4), 32'(ev));
    chk(tag, "ready", 32'(rdy4), 32'(erdy));
    if (ev) begin
      chk(tag, "res", res4, er);
      chk(tag, "ovf", 32'(ovf4), 32'(eo));
    end
  endtask

  task automatic exp1(input string tag, input logic ev, input logic [31:0] er, input logic eo, input logic erdy);
    chk(tag, "valid1", 32'(val1), 32'(ev));
    chk(tag, "ready1", 32'(rdy1), 32'(erdy));
    if (ev) begin
      chk(tag, "res1", res1, er);
      chk(tag, "ovf1", 32'(ovf1), 32'(eo));
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    exp4("reset", 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; v = 1'b0; a = '0; b = '0; last = 1'b0; sat = 1'b0; ack = 1'b0;

    // Table: basic group, then saturate/wrap in both directions. iAck held 1.
    tbl.push_back(mk(1, pk(2, 2, 2, 2),     pk(3, 3, 3, 3),     0, 0, 0, 0, 0));
    tbl.push_back(mk(1, pk(-1, -1, -1, -1), pk(5, 5, 5, 5),     0, 0, 0, 0, 0));
    tbl.push_back(mk(1, pk(7, 0, -4, 1),    pk(7, 9, 4, 1),     1, 1, 0, 0, 0));
    tbl.push_back(mk(0, '0, '0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, '0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, '0, 0, 0, 1, 32'd38, 0));
    tbl.push_back(mk(1, pk(-32768, -32768, -32768, -32768), pk(-32768, -32768, -32768, -32768), 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, pk(-32768, -32768, -32768, -32768), pk(-32768, -32768, -32768, -32768), 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, '0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, '0, 0, 0, 1, 32'h7FFF_FFFF, 1));
    tbl.push_back(mk(0, '0, '0, 0, 0, 1, 32'h0000_0000, 1));
    tbl.push_back(mk(0, '0, '0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, pk(-32768, -32768, -32768, -32768), pk(32767, 32767, 32767, 32767), 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, pk(-32768, -32768, -32768, -32768), pk(32767, 32767, 32767, 32767), 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, '0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, '0, 0, 0, 1, 32'h8000_0000, 1));
    tbl.push_back(mk(0, '0, '0, 0, 0, 1, 32'h0002_0000, 1));
    tbl.push_back(mk(0, '0, '0, 0, 0, 0, 0, 0));

    do_reset();
    foreach (tbl[i]) begin
      drive(1'b0, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].last, tbl[i].sat, 1'b1);
      exp4($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].eres, tbl[i].eovf, 1'b1);
    end

    // Back-pressure: A=1, B=2 back-to-back, acknowledge withheld 2 cycles.
    drive(1'b0, 1'b1, pk(1, 0, 0, 0), pk(1, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    exp4("bp_c0", 1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, pk(1, 0, 0, 0), pk(2, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    exp4("bp_c1", 1'b0, '0, 1'b0, 1'b1);
    idle(1'b0); exp4("bp_c2", 1'b0, '0, 1'b0, 1'b1);
    idle(1'b0); exp4("bp_c3", 1'b1, 32'd1, 1'b0, 1'b0);
    idle(1'b0); exp4("bp_c4", 1'b1, 32'd1, 1'b0, 1'b0);
    idle(1'b1); exp4("bp_c5", 1'b1, 32'd1, 1'b0, 1'b1);
    idle(1'b0); exp4("bp_c6", 1'b1, 32'd2, 1'b0, 1'b0);
    idle(1'b1); exp4("bp_c7", 1'b1, 32'd2, 1'b0, 1'b1);
    idle(1'b1); exp4("bp_c8", 1'b0, '0, 1'b0, 1'b1);
    idle(1'b1); exp4("bp_c9", 1'b0, '0, 1'b0, 1'b1);

    // Acknowledge on the same edge a new result lands.
    drive(1'b0, 1'b1, pk(3, 0, 0, 0), pk(1, 0, 0, 0), 1'b1, 1'b0, 1'b1);
    exp4("sa_c0", 1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, pk(4, 0, 0, 0), pk(1, 0, 0, 0), 1'b1, 1'b0, 1'b1);
    exp4("sa_c1", 1'b0, '0, 1'b0, 1'b1);
    idle(1'b1); exp4("sa_c2", 1'b0, '0, 1'b0, 1'b1);
    idle(1'b1); exp4("sa_c3", 1'b1, 32'd3, 1'b0, 1'b1);
    idle(1'b1); exp4("sa_c4", 1'b1, 32'd4, 1'b0, 1'b1);
    idle(1'b1); exp4("sa_c5", 1'b0, '0, 1'b0, 1'b1);

    // Reset mid-group, overriding a last beat in the reset cycle.
    drive(1'b0, 1'b1, pk(3, 3, 0, 0), pk(3, 3, 0, 0), 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, pk(3, 3, 0, 0), pk(3, 3, 0, 0), 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, pk(7, 0, 0, 0), pk(7, 0, 0, 0), 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, pk(5, 0, 0, 0), pk(5, 0, 0, 0), 1'b1, 1'b0, 1'b1);
    exp4("rst_c3", 1'b0, '0, 1'b0, 1'b1);
    idle(1'b1); exp4("rst_c4", 1'b0, '0, 1'b0, 1'b1);
    idle(1'b1); exp4("rst_c5", 1'b0, '0, 1'b0, 1'b1);
    idle(1'b1); exp4("rst_c6", 1'b1, 32'd25, 1'b0, 1'b1);
    idle(1'b1); exp4("rst_c7", 1'b0, '0, 1'b0, 1'b1);

    // Reset while a result is pending discards it.
    drive(1'b0, 1'b1, pk(1, 0, 0, 0), pk(1, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0);
    idle(1'b0); exp4("rp_c3", 1'b1, 32'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle(1'b0); exp4("rp_c5", 1'b0, '0, 1'b0, 1'b1);

    // Bubbles: 4-beat group of 1x1 on alternate cycles; junk operands on bubbles.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, (i % 2) == 0,
            ((i % 2) == 0) ? pk(1, 0, 0, 0) : pk(9, 9, 9, 9),
            ((i % 2) == 0) ? pk(1, 0, 0, 0) : pk(9, 9, 9, 9),
            i == 6, 1'b1, 1'b1);
      exp4($sformatf("bub_c%0d", i), 1'b0, '0, 1'b0, 1'b1);
    end
    idle(1'b1); exp4("bub_c7", 1'b0, '0, 1'b0, 1'b1); exp1("bub_c7", 1'b0, '0, 1'b0, 1'b1);
    idle(1'b1); exp4("bub_c8", 1'b0, '0, 1'b0, 1'b1); exp1("bub_c8", 1'b0, '0, 1'b0, 1'b1);
    idle(1'b1); exp4("bub_c9", 1'b1, 32'd4, 1'b0, 1'b1); exp1("bub_c9", 1'b1, 32'd4, 1'b0, 1'b1);
    idle(1'b1); exp4("bub_c10", 1'b0, '0, 1'b0, 1'b1); exp1("bub_c10", 1'b0, '0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_mac.md
# vector_mac

Parametrised multi-lane signed multiply-accumulator: the next generation of the single-lane MAC in the arithmetic datapath. Each accepted beat multiplies LANES signed operand pairs, sums the products, and adds the sum into a wide accumulator. A beat flagged last closes the group, and the result is presented on a held output with valid/acknowledge handshake. Output conversion is either saturating or wrapping, selected per group, with overflow flagging.

## Interface
- INPUT_LENGTH, 16: signed width of each lane operand.
- LANES, 4: number of multiplier lanes (≥1).
- ACC_LENGTH, 40: internal accumulator width; must be ≥ 2*INPUT_LENGTH + clog2(LANES) + 4.
- OUTPUT_LENGTH, 32: result width; must be ≤ ACC_LENGTH.
- iClk  in  1  clock; all state updates on its rising edge.
- iRst  in  1  reset, synchronous, active-high.
- iValid  in  1  beat present on iA/iB.
- iA  in  LANES*INPUT_LENGTH  packed operands; lane k at [k*INPUT_LENGTH +: INPUT_LENGTH], two's complement.
- iB  in  LANES*INPUT_LENGTH  packed operands, same packing.
- iLast  in  1  this beat closes the current group; qualified by iValid.
- iSat  in  1  conversion mode for the group; sampled with the last beat: 1 = saturate, 0 = wrap.
- iAck  in  1  consumer takes oRes this cycle.
- oReady  out  1  beat accepted when iValid && oReady.
- oRes  out  OUTPUT_LENGTH  converted group result, signed.
- oValid  out  1  oRes holds an unacknowledged result.
- oOverflow  out  1  group sum was outside the signed OUTPUT_LENGTH range; valid with oValid.

## Operation
- Pipeline enable: en = !(oValid && !iAck). oReady = en (combinational). When en = 0, every stage register and the accumulator hold.
- S1 (on an edge with en): captures LANES full-precision signed products (2*INPUT_LENGTH bits each), plus v1 = iValid && oReady, last1 = iLast, sat1 = iSat.
- S2 (on an edge with en): captures the sum of the S1 products, sign-extended to ACC_LENGTH, plus v2, last2, sat2 from S1.
- S3 (on an edge with en, v2 = 1): computes t = acc + sum2 modulo 2^ACC_LENGTH.
  - If last2 = 0: acc ← t.
  - If last2 = 1: acc ← 0, oValid ← 1, oOverflow ← (t outside the signed OUTPUT_LENGTH range), and oRes ← conversion of t.
- Conversion of t:
  - With sat2 = 1: clamp to 2^(OUTPUT_LENGTH-1)-1 or -2^(OUTPUT_LENGTH-1).
  - With sat2 = 0: t[OUTPUT_LENGTH-1:0].
- Invalid beats (v = 0) propagate as bubbles and leave acc untouched.
- oValid clears on an edge where iAck = 1, unless a new last result is written in the same edge. In that case oValid stays 1 and oRes and oOverflow take the new values.
- iAck while oValid = 0 is ignored.
- Groups may be back-to-back. A single-beat group (iLast on its only beat) is legal. Groups of any length are allowed; the accumulator wraps silently at ACC_LENGTH.

## Timing
- Reset, on an edge with iRst = 1: S1/S2 valid flags, acc, oRes, oValid and oOverflow all go to 0. oReady reads 1 in the following cycle. Reset overrides iValid and iAck in the same cycle. Reset mid-group or with a pending result discards all state; nothing from before reset ever appears on oRes.
- Latency: a last beat accepted in cycle c gives oValid = 1 in cycle c+3, provided no stall occurs in cycles c..c+2.
- Throughput: one beat per cycle while oReady = 1.
- Stall: each cycle with oValid && !iAck delays all in-flight beats by one cycle. oReady is low during those cycles, so the source must hold its beat.
- oRes, oValid and oOverflow are registered. oReady depends combinationally on oValid and iAck only.

## Test plan
- Reset, then iAck tied 1, LANES=4. Stream 3 beats in consecutive cycles (cycles 0-2):
  - Beat 1: all lanes 2×3.
  - Beat 2: all lanes -1×5.
  - Beat 3: lanes 7×7, 0×9, -4×4, 1×1, with iLast on this beat.
  - Required: oValid = 1 in cycle 5 only, with oRes = 24 - 20 + 34 = 38 and oOverflow = 0.
- Single-beat group, iSat = 1, all lanes -32768×-32768. Sum 2^32 exceeds the 32-bit range, so required: oRes = 0x7FFFFFFF, oOverflow = 1. Same stimulus with iSat = 0: oRes = 0x00000000, oOverflow = 1.
- Back-to-back single-beat groups A = 1 (one lane 1×1) and B = 2 (one lane 1×2), iAck = 0 until 2 cycles after A appears:
  - oRes holds 1 and oReady = 0 while unacknowledged.
  - After iAck, B appears with oRes = 2.
  - No beat is lost or duplicated, and the accumulator is clean (B not 3).
- iAck asserted on the same edge a new last result lands: oValid remains 1, oRes updates to the new value, and oReady stays 1.
- Assert iRst one cycle after accepting the first 2 beats of a group, then send a fresh single-beat group 5×5 on lane 0: oValid stays 0 until that group, which reads oRes = 25.
- Bubbles: alternate iValid 1/0 across a 4-beat group of lane values 1×1. oRes = 4 (LANES=1 build also checked), arriving 3 cycles after the last beat.
